// File: rtl/if_id_skid_reg.sv
// IF/ID boundary register with a 2-entry skid buffer and a saturating stall counter.
// Latency: a word accepted at edge N is on out_npc/out_ir with out_valid=1 right after edge N.
// Backpressure: in_ready drops only when both entries are held; flush empties the buffer at once.
module if_id_skid_reg #(
    parameter int             DW    = 32,
    parameter logic [DW-1:0]  NOP   = {DW{1'b0}},
    parameter int             CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [DW-1:0]    in_npc,
    input  logic [DW-1:0]    in_ir,
    output logic             in_ready,
    output logic             out_valid,
    output logic [DW-1:0]    out_npc,
    output logic [DW-1:0]    out_ir,
    input  logic             out_ready,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    // EMPTY: nothing held; BUSY: main register valid; FULL: main and skid both valid
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [DW-1:0]   skid_npc;
    logic [DW-1:0]   skid_ir;
    logic            accept;
    logic            take;

    assign accept = in_valid & in_ready;
    assign take   = out_valid & out_ready;

    // State register; the handshake outputs decode straight from it so they stay registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; flush overrides any same-cycle accept or take
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY:   if (accept) state_d = BUSY;
                BUSY: begin
                    if (accept && !take)      state_d = FULL;
                    else if (!accept && take) state_d = EMPTY;
                end
                FULL:    if (take) state_d = BUSY;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Handshake and occupancy outputs as a pure decode of the state register
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        occupancy = 2'd0;
        case (state_q)
            BUSY: begin
                out_valid = 1'b1;
                occupancy = 2'd1;
            end
            FULL: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
                occupancy = 2'd2;
            end
            default: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
                occupancy = 2'd0;
            end
        endcase
    end

    // Main (decode-facing) and skid registers; out_npc is left alone when the slot empties
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_npc  <= '0;
            out_ir   <= NOP;
            skid_npc <= '0;
            skid_ir  <= '0;
        end else if (flush) begin
            out_ir <= NOP;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        out_npc <= in_npc;
                        out_ir  <= in_ir;
                    end
                end
                BUSY: begin
                    if (accept && take) begin
                        out_npc <= in_npc;
                        out_ir  <= in_ir;
                    end else if (accept) begin
                        skid_npc <= in_npc;
                        skid_ir  <= in_ir;
                    end else if (take) begin
                        out_ir <= NOP;
                    end
                end
                FULL: begin
                    if (take) begin
                        out_npc <= skid_npc;
                        out_ir  <= skid_ir;
                    end
                end
                default: begin
                    out_ir <= NOP;
                end
            endcase
        end
    end

    // Count cycles where fetch is held off; sticks at all-ones until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (in_valid && !in_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed and random stimulus against if_id_skid_reg with a queue scoreboard.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// A second instance with a 2-bit stall counter shares the stimulus for saturation checks.
module tb_if_id_skid_reg;

    localparam int          DW  = 32;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_npc;
    logic [DW-1:0] in_ir;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_npc;
    logic [DW-1:0] out_ir;
    logic          out_ready;
    logic [1:0]    occupancy;
    logic [15:0]   stall_cnt;

    logic          d2_in_ready;
    logic          d2_out_valid;
    logic [DW-1:0] d2_out_npc;
    logic [DW-1:0] d2_out_ir;
    logic [1:0]    d2_occupancy;
    logic [1:0]    d2_stall_cnt;

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    if_id_skid_reg #(.DW(DW), .NOP(NOP), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_npc(in_npc), .in_ir(in_ir), .in_ready(in_ready),
        .out_valid(out_valid), .out_npc(out_npc), .out_ir(out_ir), .out_ready(out_ready),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    if_id_skid_reg #(.DW(DW), .NOP(NOP), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_npc(in_npc), .in_ir(in_ir), .in_ready(d2_in_ready),
        .out_valid(d2_out_valid), .out_npc(d2_out_npc), .out_ir(d2_out_ir), .out_ready(out_ready),
        .occupancy(d2_occupancy), .stall_cnt(d2_stall_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, score handshakes before the edge, check state after it
    task automatic cycle(input logic v, input logic [31:0] npc, input logic [31:0] ir,
                         input logic rdy, input logic fl);
        logic [63:0] exp;
        in_valid  = v;
        in_npc    = npc;
        in_ir     = ir;
        out_ready = rdy;
        flush     = fl;
        #1;
        chk("in_ready", 64'(in_ready), 64'(sb.size() < 2));
        chk("out_valid", 64'(out_valid), 64'(sb.size() > 0));
        if (fl) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready && sb.size() > 0) begin
                exp = sb.pop_front();
                chk("out_npc", 64'(out_npc), 64'(exp[63:32]));
                chk("out_ir", 64'(out_ir), 64'(exp[31:0]));
            end
            if (in_valid && in_ready) sb.push_back({npc, ir});
        end
        @(posedge clk);
        @(negedge clk);
        chk("occupancy", 64'(occupancy), 64'(sb.size()));
        if (!out_valid) chk("bubble_nop", 64'(out_ir), 64'(NOP));
    endtask

    // Assert reset between edges and confirm outputs go to reset values without a clock
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_out_ir", 64'(out_ir), 64'(NOP));
        chk("rst_out_npc", 64'(out_npc), 64'd0);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_npc    = '0;
        in_ir     = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-stream: fill to FULL first
        cycle(1'b1, 32'h0000_1004, 32'h1111_1111, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_1008, 32'h2222_2222, 1'b0, 1'b0);
        chk("pre_rst_occupancy", 64'(occupancy), 64'd2);
        do_reset();

        // Streaming: each word appears one cycle later, occupancy stays at 1
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 32'h0000_0400 + 32'(4 * i), 32'h2008_0001 + 32'(i), 1'b1, 1'b0);
            chk("stream_ir", 64'(out_ir), 64'(32'h2008_0001 + 32'(i)));
            chk("stream_occ", 64'(occupancy), 64'd1);
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Stall: A then B with decode stalled, then drain A, B in order
        cycle(1'b1, 32'h0000_0104, 32'h8C01_0004, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_0108, 32'h8C02_0008, 1'b0, 1'b0);
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        chk("stall_hold_ir", 64'(out_ir), 64'h8C01_0004);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("stall_still_A", 64'(out_ir), 64'h8C01_0004);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("release_B", 64'(out_ir), 64'h8C02_0008);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush while FULL with a word offered: everything squashed, npc held
        cycle(1'b1, 32'h0000_0204, 32'hAAAA_0001, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_0208, 32'hAAAA_0002, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_020C, 32'hDEAD_BEEF, 1'b1, 1'b1);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_out_ir", 64'(out_ir), 64'(NOP));
        chk("flush_npc_held", 64'(out_npc), 64'h0000_0204);
        repeat (3) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Stall counter: 5 held cycles, then saturation on the 2-bit instance
        do_reset();
        cycle(1'b1, 32'h0000_0304, 32'h3333_0001, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_0308, 32'h3333_0002, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'h0000_030C, 32'h3333_0003, 1'b0, 1'b0);
        chk("stall_cnt_5", 64'(stall_cnt), 64'd5);
        cycle(1'b1, 32'h0000_030C, 32'h3333_0003, 1'b0, 1'b0);
        chk("stall_cnt_6", 64'(stall_cnt), 64'd6);
        chk("stall_cnt_sat", 64'(d2_stall_cnt), 64'd3);

        // Random valid/ready against the scoreboard
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            cycle(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("drain_empty", 64'(occupancy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
